alu_driver: RTL
===============

# alu_driver

Multi-cycle issue controller that drives the shared combinational ALU on behalf of the CPU datapath. It accepts one decoded RV32I instruction per handshake and maps it onto one or two ALU passes. It generates `a`, `b` and `alu_ctrl`, then samples `alu_out`, `zero` and `carry` back. It returns the architectural result, the next PC, the branch decision and an illegal-instruction flag through a valid/ready output handshake.

## Interface
- `WIDTH`, 32, datapath width for operands, PC and result.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  instruction fields valid.
- `in_ready`  out  1  block can accept an instruction.
- `opcode`  in  7  instruction opcode.
- `funct3`  in  3  instruction funct3.
- `funct7b5`  in  1  instruction bit 30.
- `rs1_data`, `rs2_data`, `imm`, `pc`  in  WIDTH each  operands, sign-extended immediate, instruction PC.
- `a`, `b`  out  WIDTH  ALU operands.
- `alu_ctrl`  out  4  ALU operation select.
- `alu_out`  in  WIDTH  ALU result.
- `zero`  in  1  ALU zero flag.
- `carry`  in  1  ALU carry/borrow flag.
- `out_valid`  out  1  result fields valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  WIDTH  value to write back.
- `next_pc`  out  WIDTH  PC of the next instruction.
- `branch_taken`  out  1  the branch or jump redirects the PC.
- `illegal`  out  1  unsupported opcode or funct3.

## Operation
- ALU control codes: ADD 0000, SUB 0001, AND 0010, OR 0011, SLL 0100, SLT 0101, SLTU 0110, XOR 0111, SRA 1000, SRL 1001.
- FSM states: IDLE, P1, P2, DONE.
  - IDLE: `in_ready`=1. On accept, latch all input fields and go to P1.
  - P1: drive first operation and register ALU outputs. Go to P2 for JAL, JALR and taken branches; otherwise go to DONE.
  - P2: drive second operation and register the result. Go to DONE.
  - DONE: `out_valid`=1 and all outputs held stable. On `out_ready`, go to IDLE.
- `a`/`b`/`alu_ctrl` are 0/0/0000 outside P1 and P2.
- Decode for P1:
  - R-type (0110011): rs1, rs2. funct3 000 selects SUB when `funct7b5`=1, ADD otherwise. funct3 101 selects SRA when `funct7b5`=1, SRL otherwise.
  - I-ALU (0010011): rs1, imm. Same mapping as R-type, except 000 is always ADD.
  - LUI (0110111): 0 + imm.
  - AUIPC (0010111): pc + imm.
  - Load (0000011) and store (0100011): rs1 + imm (address returned in `result`).
  - Branch (1100011):
    - BEQ/BNE: SUB. Taken on `zero` / `!zero`.
    - BLT/BGE: SLT. Taken on `!zero` / `zero`.
    - BLTU/BGEU: SLTU. Taken on `!zero` / `zero`.
  - JAL (1101111): P1 computes pc+imm.
  - JALR (1100111): P1 computes rs1+imm.
- P2 operation:
  - Taken branch: pc+imm to `next_pc`.
  - JAL/JALR: pc+4 to `result`. The P1 target goes to `next_pc`; for JALR, bit 0 is forced to 0.
- `next_pc` = pc+4 for all non-redirecting instructions. This sum uses a local adder, not the ALU.
- `result` = 0 for branches.
- Illegal cases: an unknown opcode, or branch funct3 010/011, sets `illegal`=1, `result`=0, `next_pc`=pc+4 and skips P1 (IDLE→DONE).
- All arithmetic is modulo 2^WIDTH. pc+4 and pc+imm wrap silently.

## Timing
- Reset (`reset_n`=0 at a rising edge): state IDLE. `out_valid`, `result`, `next_pc`, `branch_taken`, `illegal`, `a`, `b`, `alu_ctrl` are all 0. `in_ready`=1 from the first cycle after reset.
- Reset mid-operation aborts the instruction; no `out_valid` is produced for it.
- Latency from the accept edge to `out_valid` high:
  - 1 cycle for illegal instructions.
  - 2 cycles for single-pass instructions and not-taken branches.
  - 3 cycles for taken branches and jumps.
- `out_valid` with `out_ready` low: outputs hold indefinitely.
- `in_ready` is low throughout P1, P2 and DONE. There is no overlap between instructions, so back-to-back throughput is one instruction per latency+1 cycles.
- Outputs are registered. ALU inputs are sampled at the end of P1/P2 only.

## Configuration
- `ALU_DRV_CARRY_CMP_EN`:
  - Defined: BLTU/BGEU issue SUB in P1. BLTU is taken on `carry`=1, BGEU on `carry`=0.
  - Undefined: BLTU/BGEU use SLTU with `zero`, as specified above.
- Latency and the illegal-instruction rules are identical in both builds.

## Test plan
- R-type SUB, rs1=5, rs2=7 → P1 `alu_ctrl`=0001; `result`=0xFFFFFFFE; `next_pc`=pc+4; `out_valid` 2 cycles after accept.
- BLTU, rs1=1, rs2=0xFFFFFFFF, pc=0x100, imm=0x20 → `branch_taken`=1, `next_pc`=0x120, latency 3. Run in both macro builds.
- BEQ, rs1=3, rs2=4 → `branch_taken`=0, `next_pc`=pc+4, latency 2.
- JALR, rs1=0x1001, imm=2, pc=0x40 → `next_pc`=0x1002, `result`=0x44, `branch_taken`=1.
- Opcode 0x7F → `illegal`=1, `result`=0, latency 1. Then hold `out_ready`=0 for 5 cycles → outputs stable and `in_ready`=0 throughout.
- Assert `reset_n`=0 during P2 of a JAL → next cycle IDLE with all outputs 0, `in_ready`=1, and no `out_valid` produced.

Source files
------------

// File: rtl/alu_driver.sv
// alu_driver: multi-cycle issue controller driving a shared combinational ALU for RV32I instructions.
// Latency: accept -> out_valid in 1 cycle (illegal), 2 cycles (single pass / not-taken branch), 3 cycles (taken branch / jump).
// Backpressure: one instruction in flight; in_ready only in IDLE, DONE holds all outputs until out_ready.
//
// Ports: clk/reset_n (synchronous, active-low); in_valid/in_ready + opcode, funct3, funct7b5,
//   rs1_data, rs2_data, imm, pc (instruction in); a/b/alu_ctrl out to the ALU, alu_out/zero/carry back;
//   out_valid/out_ready + result, next_pc, branch_taken, illegal (result out).
// Build option: ALU_DRV_CARRY_CMP_EN makes BLTU/BGEU issue SUB and resolve on the ALU carry/borrow flag.
module alu_driver #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             zero,
  input  logic             carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] next_pc,
  output logic             branch_taken,
  output logic             illegal
);

  typedef enum logic [1:0] {IDLE, P1, P2, DONE} state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] C_ADD  = 4'b0000;
  localparam logic [3:0] C_SUB  = 4'b0001;
  localparam logic [3:0] C_AND  = 4'b0010;
  localparam logic [3:0] C_OR   = 4'b0011;
  localparam logic [3:0] C_SLL  = 4'b0100;
  localparam logic [3:0] C_SLT  = 4'b0101;
  localparam logic [3:0] C_SLTU = 4'b0110;
  localparam logic [3:0] C_XOR  = 4'b0111;
  localparam logic [3:0] C_SRA  = 4'b1000;
  localparam logic [3:0] C_SRL  = 4'b1001;

  state_t           state;
  logic [6:0]       op_q;
  logic [2:0]       f3_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] imm_q;

  logic [WIDTH-1:0] dec_a, dec_b;
  logic [3:0]       dec_ctrl;
  logic             dec_ill;
  logic             br_cond;
  logic [WIDTH-1:0] pc_plus4;

  function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_fn = alt ? C_SUB : C_ADD;
      3'b001:  alu_fn = C_SLL;
      3'b010:  alu_fn = C_SLT;
      3'b011:  alu_fn = C_SLTU;
      3'b100:  alu_fn = C_XOR;
      3'b101:  alu_fn = alt ? C_SRA : C_SRL;
      3'b110:  alu_fn = C_OR;
      default: alu_fn = C_AND;
    endcase
  endfunction

  // First-pass decode works straight off the input fields so the P1 operands are registered at accept.
  always_comb begin
    dec_a    = '0;
    dec_b    = '0;
    dec_ctrl = C_ADD;
    dec_ill  = 1'b0;
    case (opcode)
      OP_R:     begin dec_a = rs1_data; dec_b = rs2_data; dec_ctrl = alu_fn(funct3, funct7b5); end
      OP_I:     begin dec_a = rs1_data; dec_b = imm; dec_ctrl = alu_fn(funct3, funct7b5 && (funct3 == 3'b101)); end
      OP_LUI:   dec_b = imm;
      OP_AUIPC: begin dec_a = pc; dec_b = imm; end
      OP_LOAD, OP_STORE, OP_JALR: begin dec_a = rs1_data; dec_b = imm; end
      OP_JAL:   begin dec_a = pc; dec_b = imm; end
      OP_BRANCH: begin
        dec_a = rs1_data;
        dec_b = rs2_data;
        case (funct3)
          3'b000, 3'b001: dec_ctrl = C_SUB;
          3'b100, 3'b101: dec_ctrl = C_SLT;
`ifdef ALU_DRV_CARRY_CMP_EN
          3'b110, 3'b111: dec_ctrl = C_SUB;
`else
          3'b110, 3'b111: dec_ctrl = C_SLTU;
`endif
          default:        dec_ill  = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Branch decision from the P1 flags: SUB gives equality via zero, SLT/SLTU give "less" as a nonzero result.
  always_comb begin
    case (f3_q)
      3'b000:  br_cond = zero;
      3'b001:  br_cond = !zero;
      3'b100:  br_cond = !zero;
      3'b101:  br_cond = zero;
`ifdef ALU_DRV_CARRY_CMP_EN
      3'b110:  br_cond = carry;
      3'b111:  br_cond = !carry;
`else
      3'b110:  br_cond = !zero;
      3'b111:  br_cond = zero;
`endif
      default: br_cond = 1'b0;
    endcase
  end

  wire unused_carry = &{1'b0, carry};

  // Single local adder: input pc in IDLE (illegal path), latched pc afterwards.
  assign pc_plus4 = ((state == IDLE) ? pc : pc_q) + WIDTH'(4);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      op_q         <= '0;
      f3_q         <= '0;
      pc_q         <= '0;
      imm_q        <= '0;
      a            <= '0;
      b            <= '0;
      alu_ctrl     <= '0;
      result       <= '0;
      next_pc      <= '0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q         <= opcode;
          f3_q         <= funct3;
          pc_q         <= pc;
          imm_q        <= imm;
          illegal      <= dec_ill;
          branch_taken <= 1'b0;
          result       <= '0;
          if (dec_ill) begin
            next_pc <= pc_plus4;
            state   <= DONE;
          end else begin
            a        <= dec_a;
            b        <= dec_b;
            alu_ctrl <= dec_ctrl;
            state    <= P1;
          end
        end
        P1: begin
          if (op_q == OP_JAL || op_q == OP_JALR) begin
            next_pc  <= (op_q == OP_JALR) ? {alu_out[WIDTH-1:1], 1'b0} : alu_out;
            a        <= pc_q;
            b        <= WIDTH'(4);
            alu_ctrl <= C_ADD;
            state    <= P2;
          end else if (op_q == OP_BRANCH && br_cond) begin
            a        <= pc_q;
            b        <= imm_q;
            alu_ctrl <= C_ADD;
            state    <= P2;
          end else begin
            if (op_q != OP_BRANCH) result <= alu_out;
            next_pc  <= pc_plus4;
            a        <= '0;
            b        <= '0;
            alu_ctrl <= '0;
            state    <= DONE;
          end
        end
        P2: begin
          // Taken branch puts the target in next_pc; jumps return the link address.
          if (op_q == OP_BRANCH) next_pc <= alu_out;
          else                   result  <= alu_out;
          branch_taken <= 1'b1;
          a            <= '0;
          b            <= '0;
          alu_ctrl     <= '0;
          state        <= DONE;
        end
        default: if (out_ready) state <= IDLE;
      endcase
    end
  end

endmodule
